// File: rtl/motor_rate_shaper_if.sv
// Purpose: bundles the flight-controller command side and the motor-rate side of motor_rate_shaper.
// Latency: none; wires only.
// Backpressure: none; target_valid is a single-cycle strobe with no ready.
interface motor_rate_shaper_if #(
    parameter int RATE_WIDTH = 8
);
    logic                  kill;
    logic                  arm_req;
    logic                  target_valid;
    logic [RATE_WIDTH-1:0] target_1;
    logic [RATE_WIDTH-1:0] target_2;
    logic [RATE_WIDTH-1:0] target_3;
    logic [RATE_WIDTH-1:0] target_4;
    logic [RATE_WIDTH-1:0] motor_1_rate;
    logic [RATE_WIDTH-1:0] motor_2_rate;
    logic [RATE_WIDTH-1:0] motor_3_rate;
    logic [RATE_WIDTH-1:0] motor_4_rate;
    logic                  armed;
    logic                  failsafe_active;
    logic [1:0]            state;

    // Flight controller side: issues commands, observes rates and status.
    modport master (
        output kill, arm_req, target_valid, target_1, target_2, target_3, target_4,
        input  motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate,
        input  armed, failsafe_active, state
    );

    // Shaper side: consumes commands, drives rates and status.
    modport slave (
        input  kill, arm_req, target_valid, target_1, target_2, target_3, target_4,
        output motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate,
        output armed, failsafe_active, state
    );
endinterface

// File: rtl/motor_rate_shaper.sv
// Purpose: latches motor targets, enforces arming, clamps, slew-limits and watchdogs the four motor rates.
// Latency: target latch 1 cycle; rate changes appear the cycle after a tick edge; kill takes effect next edge.
// Backpressure: none; every target_valid strobe is accepted and overwrites the latched targets.
module motor_rate_shaper #(
    parameter int RATE_WIDTH  = 8,
    parameter int MAX_RATE    = 250,
    parameter int SLEW_STEP   = 4,
    parameter int TICK_US     = 1000,
    parameter int ARM_THRESH  = 10,
    parameter int ARM_HOLD_US = 500000,
    parameter int TIMEOUT_US  = 100000
) (
    input logic                us_clk,
    input logic                rst,
    motor_rate_shaper_if.slave bus
);

    localparam logic [1:0] DISARMED = 2'd0;
    localparam logic [1:0] ARMING   = 2'd1;
    localparam logic [1:0] ARMED    = 2'd2;
    localparam logic [1:0] FAILSAFE = 2'd3;

    localparam int TICK_W = $clog2(TICK_US + 1);
    localparam int HOLD_W = $clog2(ARM_HOLD_US + 1);
    localparam int WD_W   = $clog2(TIMEOUT_US + 1);

    localparam logic [RATE_WIDTH-1:0] MAX_R = RATE_WIDTH'(MAX_RATE);
    localparam logic [RATE_WIDTH-1:0] THR_R = RATE_WIDTH'(ARM_THRESH);

    logic [1:0]            state_q;
    logic [TICK_W-1:0]     tick_cnt;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [WD_W-1:0]       wd_cnt;
    logic [RATE_WIDTH-1:0] tgt_q   [4];
    logic [RATE_WIDTH-1:0] out_q   [4];
    logic [RATE_WIDTH-1:0] tgt_in  [4];
    logic [RATE_WIDTH-1:0] arm_nxt [4];
    logic [RATE_WIDTH-1:0] fs_nxt  [4];
    logic                  tick;
    logic                  tgt_low;
    logic                  fs_all_zero;

    // Move cur toward tgt by at most SLEW_STEP, computed one bit wider so nothing wraps.
    function automatic logic [RATE_WIDTH-1:0] slew_toward(
        input logic [RATE_WIDTH-1:0] cur,
        input logic [RATE_WIDTH-1:0] tgt
    );
        logic [RATE_WIDTH:0] c;
        logic [RATE_WIDTH:0] t;
        logic [RATE_WIDTH:0] gap;
        logic [RATE_WIDTH:0] stp;
        c   = {1'b0, cur};
        t   = {1'b0, tgt};
        stp = (RATE_WIDTH + 1)'(SLEW_STEP);
        if (t >= c) begin
            gap = t - c;
            slew_toward = RATE_WIDTH'(c + ((gap < stp) ? gap : stp));
        end else begin
            gap = c - t;
            slew_toward = RATE_WIDTH'(c - ((gap < stp) ? gap : stp));
        end
    endfunction

    assign tgt_in[0] = bus.target_1;
    assign tgt_in[1] = bus.target_2;
    assign tgt_in[2] = bus.target_3;
    assign tgt_in[3] = bus.target_4;

    assign tick = (tick_cnt == TICK_W'(TICK_US - 1));

    // Candidate next rates for ARMED (toward latched target) and FAILSAFE (toward zero), plus arm gating.
    always_comb begin
        tgt_low     = 1'b1;
        fs_all_zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            arm_nxt[i] = tick ? slew_toward(out_q[i], tgt_q[i]) : out_q[i];
            fs_nxt[i]  = tick ? slew_toward(out_q[i], '0) : out_q[i];
            if (tgt_q[i] > THR_R) begin
                tgt_low = 1'b0;
            end
            if (fs_nxt[i] != '0) begin
                fs_all_zero = 1'b0;
            end
        end
    end

    // Target latch, tick counter, arming/watchdog FSM and registered motor rates.
    always_ff @(posedge us_clk) begin
        if (rst) begin
            state_q  <= DISARMED;
            tick_cnt <= '0;
            hold_cnt <= '0;
            wd_cnt   <= '0;
            for (int i = 0; i < 4; i++) begin
                tgt_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);

            // The latch lands after this edge, so a coincident tick still slews toward the old target.
            if (bus.target_valid) begin
                for (int i = 0; i < 4; i++) begin
                    tgt_q[i] <= (tgt_in[i] > MAX_R) ? MAX_R : tgt_in[i];
                end
            end

            if (bus.kill) begin
                state_q <= DISARMED;
                for (int i = 0; i < 4; i++) begin
                    out_q[i] <= '0;
                end
            end else begin
                case (state_q)
                    DISARMED: begin
                        for (int i = 0; i < 4; i++) begin
                            out_q[i] <= '0;
                        end
                        if (bus.arm_req && tgt_low) begin
                            state_q  <= ARMING;
                            hold_cnt <= '0;
                        end
                    end
                    ARMING: begin
                        for (int i = 0; i < 4; i++) begin
                            out_q[i] <= '0;
                        end
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                        if (!bus.arm_req || !tgt_low) begin
                            state_q <= DISARMED;
                        end else if (hold_cnt == HOLD_W'(ARM_HOLD_US - 1)) begin
                            state_q <= ARMED;
                            wd_cnt  <= '0;
                        end
                    end
                    ARMED: begin
                        if (!bus.arm_req) begin
                            state_q <= DISARMED;
                            for (int i = 0; i < 4; i++) begin
                                out_q[i] <= '0;
                            end
                        end else begin
                            for (int i = 0; i < 4; i++) begin
                                out_q[i] <= arm_nxt[i];
                            end
                            // A fresh target on the expiry cycle keeps the link alive.
                            if (bus.target_valid) begin
                                wd_cnt <= '0;
                            end else if (wd_cnt == WD_W'(TIMEOUT_US - 1)) begin
                                state_q <= FAILSAFE;
                            end else begin
                                wd_cnt <= wd_cnt + WD_W'(1);
                            end
                        end
                    end
                    default: begin
                        if (!bus.arm_req) begin
                            state_q <= DISARMED;
                            for (int i = 0; i < 4; i++) begin
                                out_q[i] <= '0;
                            end
                        end else begin
                            for (int i = 0; i < 4; i++) begin
                                out_q[i] <= fs_nxt[i];
                            end
                            if (fs_all_zero) begin
                                state_q <= DISARMED;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.motor_1_rate    = out_q[0];
    assign bus.motor_2_rate    = out_q[1];
    assign bus.motor_3_rate    = out_q[2];
    assign bus.motor_4_rate    = out_q[3];
    assign bus.state           = state_q;
    assign bus.armed           = (state_q == ARMED);
    assign bus.failsafe_active = (state_q == FAILSAFE);

endmodule

// File: tb/tb_motor_rate_shaper.sv
// Purpose: scoreboard bench for motor_rate_shaper against a behavioural model of the arming/slew/watchdog rules.
// Latency: model result for each edge is queued at the edge and compared on the following falling edge.
// Backpressure: none; the DUT presents a full output word every cycle.
module tb_motor_rate_shaper;

    localparam int P_TICK    = 4;
    localparam int P_HOLD    = 16;
    localparam int P_TIMEOUT = 100;
    localparam int P_STEP    = 4;
    localparam int P_MAX     = 250;
    localparam int P_THRESH  = 10;

    typedef struct packed {
        logic [1:0] st;
        logic       armed;
        logic       fs;
        logic [7:0] m1;
        logic [7:0] m2;
        logic [7:0] m3;
        logic [7:0] m4;
    } obs_t;

    logic us_clk = 1'b0;
    logic rst    = 1'b1;
    logic kill   = 1'b0;
    logic arm    = 1'b0;
    logic tv     = 1'b0;
    logic [7:0] t [4] = '{8'd0, 8'd0, 8'd0, 8'd0};

    int pass_cnt  = 0;
    int total_cnt = 0;
    obs_t exp_q[$];

    // Reference model state, in plain integers.
    int m_state;
    int m_tick;
    int m_hold;
    int m_wd;
    int m_tgt [4];
    int m_out [4];

    motor_rate_shaper_if #(.RATE_WIDTH(8)) bus ();

    assign bus.kill         = kill;
    assign bus.arm_req      = arm;
    assign bus.target_valid = tv;
    assign bus.target_1     = t[0];
    assign bus.target_2     = t[1];
    assign bus.target_3     = t[2];
    assign bus.target_4     = t[3];

    motor_rate_shaper #(
        .RATE_WIDTH (8),
        .MAX_RATE   (P_MAX),
        .SLEW_STEP  (P_STEP),
        .TICK_US    (P_TICK),
        .ARM_THRESH (P_THRESH),
        .ARM_HOLD_US(P_HOLD),
        .TIMEOUT_US (P_TIMEOUT)
    ) dut (
        .us_clk(us_clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 us_clk = ~us_clk;

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One clock edge of the specified behaviour, using the inputs the bench is driving.
    task automatic model_step();
        bit tick;
        bit all_low;
        bit all_zero;
        obs_t e;
        tick = (m_tick == P_TICK - 1);
        all_low = 1;
        for (int i = 0; i < 4; i++) if (m_tgt[i] > P_THRESH) all_low = 0;
        if (rst) begin
            m_state = 0; m_tick = 0; m_hold = 0; m_wd = 0;
            for (int i = 0; i < 4; i++) begin m_tgt[i] = 0; m_out[i] = 0; end
        end else begin
            m_tick = tick ? 0 : m_tick + 1;
            if (kill) begin
                m_state = 0;
                for (int i = 0; i < 4; i++) m_out[i] = 0;
            end else if (m_state == 0) begin
                if (arm && all_low) begin m_state = 1; m_hold = 0; end
            end else if (m_state == 1) begin
                if (!arm || !all_low) m_state = 0;
                else if (m_hold == P_HOLD - 1) begin m_state = 2; m_wd = 0; end
                else m_hold++;
            end else if (!arm) begin
                m_state = 0;
                for (int i = 0; i < 4; i++) m_out[i] = 0;
            end else if (m_state == 2) begin
                if (tick)
                    for (int i = 0; i < 4; i++)
                        if (m_tgt[i] >= m_out[i]) m_out[i] += min2(P_STEP, m_tgt[i] - m_out[i]);
                        else m_out[i] -= min2(P_STEP, m_out[i] - m_tgt[i]);
                if (tv) m_wd = 0;
                else if (m_wd == P_TIMEOUT - 1) m_state = 3;
                else m_wd++;
            end else begin
                if (tick)
                    for (int i = 0; i < 4; i++) m_out[i] -= min2(P_STEP, m_out[i]);
                all_zero = 1;
                for (int i = 0; i < 4; i++) if (m_out[i] != 0) all_zero = 0;
                if (all_zero) m_state = 0;
            end
            if (tv)
                for (int i = 0; i < 4; i++) m_tgt[i] = min2(int'(t[i]), P_MAX);
        end
        e.st    = 2'(m_state);
        e.armed = (m_state == 2);
        e.fs    = (m_state == 3);
        e.m1    = 8'(m_out[0]);
        e.m2    = 8'(m_out[1]);
        e.m3    = 8'(m_out[2]);
        e.m4    = 8'(m_out[3]);
        exp_q.push_back(e);
    endtask

    // Advance n cycles from a falling edge to a falling edge with inputs held.
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge us_clk);
            model_step();
            @(negedge us_clk);
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        total_cnt++;
        if (got == want) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    task automatic set_t(input int a, input int b, input int c, input int d);
        t[0] = 8'(a); t[1] = 8'(b); t[2] = 8'(c); t[3] = 8'(d);
    endtask

    task automatic pulse_tv();
        tv = 1'b1;
        cyc(1);
        tv = 1'b0;
    endtask

    // Monitor: every falling edge the DUT output word is compared with the oldest queued expectation.
    initial begin
        obs_t got;
        obs_t e;
        forever begin
            @(negedge us_clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {bus.state, bus.armed, bus.failsafe_active,
                       bus.motor_1_rate, bus.motor_2_rate, bus.motor_3_rate, bus.motor_4_rate};
                total_cnt++;
                if (got === e) pass_cnt++;
                else $display("FAIL scoreboard @%0t: got st=%0d arm=%0b fs=%0b m=%0d,%0d,%0d,%0d expected st=%0d arm=%0b fs=%0b m=%0d,%0d,%0d,%0d",
                              $time, got.st, got.armed, got.fs, got.m1, got.m2, got.m3, got.m4,
                              e.st, e.armed, e.fs, e.m1, e.m2, e.m3, e.m4);
            end
        end
    end

    initial begin
        int tv_div;
        @(negedge us_clk);

        // Reset and arming, including an aborted attempt.
        rst = 1'b1;
        cyc(2);
        check("reset_state", int'(bus.state), 0);
        check("reset_m1", int'(bus.motor_1_rate), 0);
        rst = 1'b0;
        set_t(0, 0, 0, 0);
        pulse_tv();
        arm = 1'b1;
        cyc(8);
        arm = 1'b0;
        cyc(1);
        check("arm_abort", int'(bus.state), 0);
        arm = 1'b1;
        cyc(16);
        check("arming_hold", int'(bus.state), 1);
        cyc(1);
        check("armed_state", int'(bus.state), 2);
        check("armed_flag", int'(bus.armed), 1);

        // Slew up toward 30 on motor 1.
        set_t(30, 0, 0, 0);
        repeat (2) begin pulse_tv(); cyc(49); end
        check("slew_up_m1", int'(bus.motor_1_rate), 30);
        check("slew_up_m2", int'(bus.motor_2_rate), 0);

        // Clamp at MAX_RATE, then down-slew to an exact small target.
        set_t(30, 255, 0, 0);
        repeat (6) begin pulse_tv(); cyc(49); end
        check("clamp_m2", int'(bus.motor_2_rate), 250);
        set_t(30, 3, 0, 0);
        repeat (6) begin pulse_tv(); cyc(49); end
        check("down_slew_m2", int'(bus.motor_2_rate), 3);

        // Watchdog expiry and failsafe ramp-down.
        set_t(30, 0, 0, 0);
        pulse_tv();
        cyc(99);
        check("wd_not_yet", int'(bus.state), 2);
        cyc(1);
        check("wd_failsafe", int'(bus.state), 3);
        check("wd_fs_flag", int'(bus.failsafe_active), 1);
        cyc(40);
        check("fs_done_state", int'(bus.state), 0);
        check("fs_done_m1", int'(bus.motor_1_rate), 0);

        // Kill mid-ramp, then a full re-arm hold.
        set_t(0, 0, 0, 0);
        pulse_tv();
        cyc(20);
        set_t(20, 0, 0, 0);
        pulse_tv();
        cyc(25);
        check("pre_kill_m1", int'(bus.motor_1_rate), 20);
        kill = 1'b1;
        cyc(1);
        kill = 1'b0;
        check("kill_state", int'(bus.state), 0);
        check("kill_m1", int'(bus.motor_1_rate), 0);
        set_t(0, 0, 0, 0);
        pulse_tv();
        cyc(1);
        check("rearm_start", int'(bus.state), 1);
        cyc(15);
        check("rearm_hold", int'(bus.state), 1);
        cyc(1);
        check("rearm_done", int'(bus.state), 2);

        // Arm inhibit by a target just above threshold.
        arm = 1'b0;
        cyc(1);
        set_t(0, 0, 11, 0);
        pulse_tv();
        arm = 1'b1;
        cyc(40);
        check("inhibit", int'(bus.state), 0);
        set_t(0, 0, 10, 0);
        pulse_tv();
        cyc(1);
        check("inhibit_release", int'(bus.state), 1);

        // Randomised traffic, with the target-strobe rate varied per block to exercise the watchdog.
        for (int blk = 0; blk < 8; blk++) begin
            case ($urandom_range(0, 2))
                0: tv_div = 4;
                1: tv_div = 12;
                default: tv_div = 150;
            endcase
            for (int k = 0; k < 400; k++) begin
                rst  = ($urandom_range(0, 999) == 0);
                kill = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 149) == 0) arm = ~arm;
                tv = ($urandom_range(0, tv_div - 1) == 0);
                for (int i = 0; i < 4; i++)
                    t[i] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 10))
                                                      : 8'($urandom_range(0, 255));
                cyc(1);
            end
        end
        rst = 1'b0; kill = 1'b0; tv = 1'b0;

        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/motor_rate_shaper.md
Name: motor_rate_shaper

Overview:
- Upstream stage of pwm_generator; drives its four motor_N_rate inputs.
- Latches per-motor target rates from the flight controller.
- Enforces an arming sequence, clamps each target to MAX_RATE, slew-limits every output at a fixed tick rate, and runs a link-loss watchdog that ramps all motors to 0.
- Runs on the 1 MHz us_clk domain.

Parameters:
- RATE_WIDTH, 8: width of every target and rate bus.
- MAX_RATE, 250: upper clamp applied to targets when they are latched.
- SLEW_STEP, 4: maximum change of any output per tick.
- TICK_US, 1000: tick period in us_clk cycles.
- ARM_THRESH, 10: every target must be <= this value to arm.
- ARM_HOLD_US, 500000: number of cycles arm_req must be held to arm.
- TIMEOUT_US, 100000: watchdog limit in cycles without target_valid while ARMED.

Ports:
- us_clk  in  1  system clock, 1 MHz.
- rst  in  1  synchronous, active-high reset.
- kill  in  1  emergency stop, level-sensitive.
- arm_req  in  1  arm request, level-sensitive.
- target_valid  in  1  single-cycle strobe; targets 1-4 are valid in that cycle.
- target_1 .. target_4  in  RATE_WIDTH each  requested motor rates.
- motor_1_rate .. motor_4_rate  out  RATE_WIDTH each  registered rates to pwm_generator.
- armed  out  1  high in the ARMED state only.
- failsafe_active  out  1  high in the FAILSAFE state only.
- state  out  2  DISARMED=0, ARMING=1, ARMED=2, FAILSAFE=3.

Behaviour:
- Reset: all outputs 0, state DISARMED, all latched targets 0, every counter 0.
- Priority on each clock edge: rst > kill > all other events.
- Target latch: on target_valid, in any state, each target_N is stored as min(target_N, MAX_RATE).
- Tick counter: free-running 0..TICK_US-1. tick = (count == TICK_US-1).
- DISARMED:
  - Outputs are forced to 0.
  - Go to ARMING when arm_req=1 and all latched targets <= ARM_THRESH. The hold counter is cleared on entry.
- ARMING:
  - Outputs remain 0. The hold counter increments every cycle.
  - Return to DISARMED if arm_req=0 or any latched target > ARM_THRESH.
  - Go to ARMED on the edge where the hold counter == ARM_HOLD_US-1, so the first ARMED cycle follows ARM_HOLD_US cycles in ARMING.
  - The watchdog counter is cleared on entry to ARMED.
- ARMED:
  - On each tick edge, each output moves toward its latched target by at most SLEW_STEP: out + min(SLEW_STEP, tgt - out) going up, out - min(SLEW_STEP, out - tgt) going down.
  - Arithmetic uses RATE_WIDTH+1 bits; no wrap is permitted. The new value is visible the cycle after the tick edge.
  - Watchdog: cleared on target_valid, otherwise increments. When it reaches TIMEOUT_US-1, go to FAILSAFE.
  - arm_req=0: go to DISARMED; outputs are 0 on the next cycle.
- FAILSAFE:
  - The effective target is 0 for all motors. On each tick, outputs decrease by min(SLEW_STEP, out).
  - target_valid still updates the latched targets but does not exit FAILSAFE.
  - When all four outputs are 0 (evaluated after the tick update), go to DISARMED.
  - arm_req=0 → DISARMED immediately.
- kill=1 in any state: DISARMED and outputs 0 on the next edge. While kill stays high, the block cannot leave DISARMED.
- Simultaneous tick and target_valid: the slew step uses the previously latched target. The new target takes effect from the next tick.
- Simultaneous target_valid and watchdog expiry: target_valid wins, the counter is cleared, and the block stays ARMED.
- A target equal to the current output causes no change on a tick. A target above MAX_RATE saturates at MAX_RATE.

Test Plan:
Bench parameters: TICK_US=4, ARM_HOLD_US=16, TIMEOUT_US=100, SLEW_STEP=4, MAX_RATE=250, ARM_THRESH=10.
1. Reset then arming: rst 2 cycles, latched targets 0, arm_req=1 → state=1 for 16 cycles, then state=2 and armed=1. Dropping arm_req at cycle 8 instead → state=0.
2. Slew up: while ARMED, refresh target_1=30 every 50 cycles → motor_1_rate follows 4, 8, … 28, 30, one step per 4-cycle tick, then holds at 30; motors 2-4 remain 0.
3. Clamp and down-slew: target_2=255 → motor_2_rate saturates at 250. Then target_2=3 → it decreases by 4 per tick to exactly 3 with no underflow.
4. Watchdog: armed with motor_1_rate=30 and no target_valid for 100 cycles → state=3 and failsafe_active=1. Outputs reach 26, 22, …, 2, 0, then state=0.
5. Kill mid-ramp: motor_1_rate=20 and ARMED, pulse kill 1 cycle → next cycle all rates 0 and state=0. Re-arming requires a full 16-cycle hold.
6. Arm inhibit: target_3=11 latched, arm_req=1 → state stays 0 indefinitely. Latch target_3=10 → ARMING begins.
